timer_bank: RTL and testbench

Parametrised multi-channel memory-mapped timer peripheral for the FemtoRV32 SoC bus. It replaces the single fixed 32-bit timer in the top level with NUM_CH independent channels. Each channel has a compare value, a one-shot or periodic mode, a per-channel interrupt enable and a write-1-to-clear pending flag. It drives one combined interrupt request into the CPU interrupt OR.

---
 rtl/timer_bank.sv | 160 ++++++++++++++++
 tb/tb_timer_bank.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_bank.sv
// rtl/timer_bank.sv - Multi-channel compare timer bank with one combined interrupt
// Optional per-channel 8-bit prescaler is built when TIMER_PRESCALER_EN is defined.
module timer_bank #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32
) (
   input  logic        clk,
   input  logic        resetq,
   input  logic        sel,
   input  logic [5:0]  addr,
   input  logic [3:0]  we,
   input  logic        rd,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   localparam logic [1:0] REG_CTRL    = 2'd0;
   localparam logic [1:0] REG_COMPARE = 2'd1;
   localparam logic [1:0] REG_COUNT   = 2'd2;
   localparam logic [1:0] REG_STATUS  = 2'd3;
   localparam logic [1:0] REG_IRQ_MAP = 2'd0;
   localparam logic [3:0] GLOBAL_CH   = 4'hF;

   logic [3:0]        ch_idx;
   logic [1:0]        reg_idx;
   logic              wr_any;
   logic              unused_rd;

   logic [NUM_CH-1:0] en_q;
   logic [NUM_CH-1:0] per_q;
   logic [NUM_CH-1:0] ie_q;
   logic [NUM_CH-1:0] pend_q;
   logic [CNT_W-1:0]  cmp_q  [NUM_CH];
   logic [CNT_W-1:0]  cnt_q  [NUM_CH];
   logic [CNT_W-1:0]  cmp_wr [NUM_CH];

   logic [NUM_CH-1:0] wr_ch;
   logic [NUM_CH-1:0] w1c;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] match;
   logic [NUM_CH-1:0] irq_map;

`ifdef TIMER_PRESCALER_EN
   logic [7:0]        pre_q [NUM_CH];
   logic [7:0]        pc_q  [NUM_CH];
`endif

   assign ch_idx    = addr[5:2];
   assign reg_idx   = addr[1:0];
   assign wr_any    = sel && (we != 4'h0);
   assign unused_rd = rd;

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         wr_ch[i]   = wr_any && (ch_idx == 4'(i));
         w1c[i]     = wr_ch[i] && (reg_idx == REG_STATUS) && we[0] && wdata[0];
`ifdef TIMER_PRESCALER_EN
         tick[i]    = en_q[i] && (pc_q[i] == pre_q[i]);
`else
         tick[i]    = en_q[i];
`endif
         match[i]   = tick[i] && (cnt_q[i] == cmp_q[i]);
         irq_map[i] = pend_q[i] && ie_q[i];
         // Bytes above CNT_W simply have no bits to land in.
         for (int j = 0; j < CNT_W; j++) begin
            cmp_wr[i][j] = we[j/8] ? wdata[j] : cmp_q[i][j];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetq) begin
         en_q   <= '0;
         per_q  <= '0;
         ie_q   <= '0;
         pend_q <= '0;
         irq    <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            cmp_q[i] <= '1;
            cnt_q[i] <= '0;
`ifdef TIMER_PRESCALER_EN
            pre_q[i] <= '0;
            pc_q[i]  <= '0;
`endif
         end
      end else begin
         irq <= |irq_map;
         for (int i = 0; i < NUM_CH; i++) begin
            if (tick[i]) begin
               cnt_q[i] <= match[i] ? '0 : cnt_q[i] + CNT_W'(1);
            end
            // A hardware match beats a same-cycle clear so no event is lost.
            if (match[i]) begin
               pend_q[i] <= 1'b1;
            end else if (w1c[i]) begin
               pend_q[i] <= 1'b0;
            end
            if (match[i] && !per_q[i]) begin
               en_q[i] <= 1'b0;
            end
`ifdef TIMER_PRESCALER_EN
            pc_q[i] <= (!en_q[i] || tick[i]) ? 8'd0 : pc_q[i] + 8'd1;
`endif
            // Register writes come last so they override counting updates.
            if (wr_ch[i]) begin
               case (reg_idx)
                  REG_CTRL: begin
                     if (we[0]) begin
                        en_q[i]  <= wdata[0];
                        per_q[i] <= wdata[1];
                        ie_q[i]  <= wdata[2];
                     end
`ifdef TIMER_PRESCALER_EN
                     if (we[1]) begin
                        pre_q[i] <= wdata[15:8];
                     end
`endif
                  end
                  REG_COMPARE: cmp_q[i] <= cmp_wr[i];
                  REG_COUNT: begin
                     cnt_q[i] <= '0;
`ifdef TIMER_PRESCALER_EN
                     pc_q[i]  <= '0;
`endif
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   always_comb begin
      rdata = '0;
      if (sel) begin
         if (ch_idx == GLOBAL_CH) begin
            if (reg_idx == REG_IRQ_MAP) begin
               rdata = 32'(irq_map);
            end
         end else begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (ch_idx == 4'(i)) begin
                  case (reg_idx)
`ifdef TIMER_PRESCALER_EN
                     REG_CTRL:    rdata = {16'h0, pre_q[i], 5'h0, ie_q[i], per_q[i], en_q[i]};
`else
                     REG_CTRL:    rdata = {29'h0, ie_q[i], per_q[i], en_q[i]};
`endif
                     REG_COMPARE: rdata = 32'(cmp_q[i]);
                     REG_COUNT:   rdata = 32'(cnt_q[i]);
                     default:     rdata = {31'h0, pend_q[i]};
                  endcase
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_timer_bank.sv
// tb/tb_timer_bank.sv - Self-checking bench for timer_bank with a behavioural reference model
module tb_timer_bank;

   localparam int NCH = 4;
`ifdef TIMER_PRESCALER_EN
   localparam bit PRESC = 1'b1;
`else
   localparam bit PRESC = 1'b0;
`endif
   localparam longint unsigned MASK = 64'hFFFF_FFFF;

   typedef struct {
      bit          s;
      logic [5:0]  a;
      logic [3:0]  w;
      logic [31:0] d;
      bit          c;
      logic [31:0] e;
   } vec_t;

   logic        clk    = 1'b0;
   logic        resetq = 1'b0;
   logic        sel    = 1'b0;
   logic [5:0]  addr   = '0;
   logic [3:0]  we     = '0;
   logic        rd     = 1'b0;
   logic [31:0] wdata  = '0;
   logic [31:0] rdata;
   logic [31:0] rdata16;
   logic        irq;
   logic        irq16;

   always #5 clk = ~clk;

   timer_bank #(.NUM_CH(4), .CNT_W(32)) dut (
      .clk(clk), .resetq(resetq), .sel(sel), .addr(addr), .we(we), .rd(rd),
      .wdata(wdata), .rdata(rdata), .irq(irq)
   );

   timer_bank #(.NUM_CH(4), .CNT_W(16)) dut16 (
      .clk(clk), .resetq(resetq), .sel(sel), .addr(addr), .we(we), .rd(rd),
      .wdata(wdata), .rdata(rdata16), .irq(irq16)
   );

   bit              m_en [NCH];
   bit              m_per[NCH];
   bit              m_ie [NCH];
   bit              m_pend[NCH];
   bit              m_irq;
   longint unsigned m_cmp[NCH];
   longint unsigned m_cnt[NCH];
   int              m_pre[NCH];
   int              m_pc [NCH];

   int          checks = 0;
   int          errors = 0;
   logic [31:0] last_r16;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // One clock edge of the peripheral as the register description reads.
   task automatic model_step(input bit s, input logic [5:0] a, input logic [3:0] w,
                             input logic [31:0] d, input bit rst_n);
      int ch;
      int r;
      bit wr;
      bit nxt_irq;
      ch = int'(a[5:2]);
      r  = int'(a[1:0]);
      wr = s && (w != 4'h0);
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) begin
            m_en[c] = 0; m_per[c] = 0; m_ie[c] = 0; m_pend[c] = 0;
            m_cmp[c] = MASK; m_cnt[c] = 0; m_pre[c] = 0; m_pc[c] = 0;
         end
         m_irq = 0;
         return;
      end
      nxt_irq = 0;
      for (int c = 0; c < NCH; c++) begin
         if (m_pend[c] && m_ie[c]) nxt_irq = 1;
      end
      for (int c = 0; c < NCH; c++) begin
         bit tk;
         bit hit;
         bit here;
         longint unsigned cnt_n;
         longint unsigned cmp_n;
         int pc_n;
         bit pend_n;
         bit en_n;
         tk    = m_en[c] && (!PRESC || (m_pc[c] == m_pre[c]));
         hit   = tk && (m_cnt[c] == m_cmp[c]);
         here  = wr && (ch == c);
         cnt_n = m_cnt[c];
         if (tk) cnt_n = hit ? 0 : ((m_cnt[c] + 1) & MASK);
         pc_n  = (m_en[c] && !tk) ? ((m_pc[c] + 1) % 256) : 0;
         pend_n = m_pend[c];
         if (hit) pend_n = 1;
         else if (here && r == 3 && w[0] && d[0]) pend_n = 0;
         en_n = (hit && !m_per[c]) ? 1'b0 : m_en[c];
         if (here && r == 0) begin
            if (w[0]) begin
               en_n = d[0]; m_per[c] = d[1]; m_ie[c] = d[2];
            end
            if (w[1] && PRESC) m_pre[c] = int'(d[15:8]);
         end
         if (here && r == 1) begin
            cmp_n = m_cmp[c];
            for (int b = 0; b < 4; b++) begin
               if (w[b]) cmp_n = (cmp_n & ~(64'hFF << (8*b))) | (longint'(d[8*b +: 8]) << (8*b));
            end
            m_cmp[c] = cmp_n & MASK;
         end
         if (here && r == 2) begin
            cnt_n = 0; pc_n = 0;
         end
         m_cnt[c] = cnt_n; m_pc[c] = pc_n; m_pend[c] = pend_n; m_en[c] = en_n;
      end
      m_irq = nxt_irq;
   endtask

   function automatic logic [31:0] model_read(input bit s, input logic [5:0] a);
      int ch;
      int r;
      int map;
      ch = int'(a[5:2]);
      r  = int'(a[1:0]);
      if (!s) return 32'h0;
      if (ch == 15) begin
         map = 0;
         for (int c = 0; c < NCH; c++) if (m_pend[c] && m_ie[c]) map += (1 << c);
         return (r == 0) ? 32'(map) : 32'h0;
      end
      if (ch >= NCH) return 32'h0;
      case (r)
         0: return 32'(int'(m_en[ch]) + 2*int'(m_per[ch]) + 4*int'(m_ie[ch]) + (PRESC ? m_pre[ch]*256 : 0));
         1: return 32'(m_cmp[ch]);
         2: return 32'(m_cnt[ch]);
         default: return 32'(m_pend[ch]);
      endcase
   endfunction

   task automatic op(input bit s, input logic [5:0] a, input logic [3:0] w, input logic [31:0] d,
                     input bit chk_en, input logic [31:0] exp, input string nm);
      sel = s; addr = a; we = w; wdata = d; rd = s && (w == 4'h0);
      #1;
      last_r16 = rdata16;
      chk({nm, "_rdata_model"}, rdata, model_read(s, a));
      if (chk_en) chk(nm, rdata, exp);
      @(posedge clk);
      model_step(s, a, w, d, resetq);
      #1;
      chk({nm, "_irq_model"}, {31'h0, irq}, {31'h0, m_irq});
   endtask

   task automatic idle();
      op(1'b0, 6'h0, 4'h0, 32'h0, 1'b0, 32'h0, "idle");
   endtask

   task automatic wr(input logic [5:0] a, input logic [3:0] w, input logic [31:0] d, input string nm);
      op(1'b1, a, w, d, 1'b0, 32'h0, nm);
   endtask

   task automatic rd_chk(input logic [5:0] a, input logic [31:0] exp, input string nm);
      op(1'b1, a, 4'h0, 32'h0, 1'b1, exp, nm);
   endtask

   function automatic vec_t mk(input bit s, input logic [5:0] a, input logic [3:0] w,
                               input logic [31:0] d, input bit c, input logic [31:0] e);
      vec_t v;
      v.s = s; v.a = a; v.w = w; v.d = d; v.c = c; v.e = e;
      return v;
   endfunction

   initial begin
      vec_t tbl[$];
      int   per;

      // Reset
      resetq = 1'b0;
      idle();
      idle();
      resetq = 1'b1;
      chk("reset_irq", {31'h0, irq}, 32'h0);
      chk("reset_irq16", {31'h0, irq16}, 32'h0);
      rd_chk(6'h01, 32'hFFFF_FFFF, "reset_cmp0");
      rd_chk(6'h02, 32'h0, "reset_cnt0");
      rd_chk(6'h3C, 32'h0, "reset_irqmap");

      // Static register vectors, all channels disabled
      tbl.push_back(mk(1, 6'h09, 4'hF, 32'h1234_5678, 0, 32'h0));
      tbl.push_back(mk(1, 6'h09, 4'h0, 32'h0, 1, 32'h1234_5678));
      tbl.push_back(mk(1, 6'h09, 4'h4, 32'h00AB_0000, 0, 32'h0));
      tbl.push_back(mk(1, 6'h09, 4'h0, 32'h0, 1, 32'h12AB_5678));
      tbl.push_back(mk(1, 6'h08, 4'hF, 32'hFFFF_FF06, 0, 32'h0));
      tbl.push_back(mk(1, 6'h08, 4'h0, 32'h0, 1, PRESC ? 32'h0000_FF06 : 32'h0000_0006));
      tbl.push_back(mk(1, 6'h08, 4'h2, 32'h0000_0500, 0, 32'h0));
      tbl.push_back(mk(1, 6'h08, 4'h0, 32'h0, 1, PRESC ? 32'h0000_0506 : 32'h0000_0006));
      tbl.push_back(mk(1, 6'h15, 4'hF, 32'h0, 0, 32'h0));
      tbl.push_back(mk(1, 6'h15, 4'h0, 32'h0, 1, 32'h0));
      tbl.push_back(mk(1, 6'h1C, 4'h0, 32'h0, 1, 32'h0));
      tbl.push_back(mk(1, 6'h3D, 4'h0, 32'h0, 1, 32'h0));
      tbl.push_back(mk(0, 6'h09, 4'h0, 32'h0, 1, 32'h0));
      tbl.push_back(mk(1, 6'h0B, 4'h0, 32'h0, 1, 32'h0));
      tbl.push_back(mk(1, 6'h0A, 4'h0, 32'h0, 1, 32'h0));
      tbl.push_back(mk(1, 6'h08, 4'hF, 32'h0, 0, 32'h0));
      tbl.push_back(mk(1, 6'h08, 4'h0, 32'h0, 1, 32'h0));
      for (int i = 0; i < tbl.size(); i++) begin
         op(tbl[i].s, tbl[i].a, tbl[i].w, tbl[i].d, tbl[i].c, tbl[i].e, $sformatf("tbl%0d", i));
      end

      // One-shot on ch1: match on the 6th tick, irq a cycle later
      wr(6'h05, 4'hF, 32'd5, "os_cmp");
      wr(6'h06, 4'hF, 32'd0, "os_cnt");
      wr(6'h04, 4'hF, 32'h5, "os_ctrl");
      for (int k = 1; k <= 7; k++) begin
         rd_chk(6'h07, (k == 7) ? 32'h1 : 32'h0, $sformatf("os_status%0d", k));
         chk($sformatf("os_irq%0d", k), {31'h0, irq}, (k == 7) ? 32'h1 : 32'h0);
      end
      rd_chk(6'h04, 32'h4, "os_ctrl_after");
      rd_chk(6'h06, 32'h0, "os_cnt_after");
      wr(6'h07, 4'h1, 32'h1, "os_w1c");
      wr(6'h04, 4'hF, 32'h0, "os_off");

      // Periodic ch0, period 4; W1C on a match edge is lost, off-match clears
      wr(6'h01, 4'hF, 32'd3, "pw_cmp");
      wr(6'h02, 4'hF, 32'd0, "pw_cnt");
      wr(6'h00, 4'hF, 32'h7, "pw_ctrl");
      for (int k = 1; k <= 7; k++) idle();
      wr(6'h03, 4'h1, 32'h1, "pw_w1c_match");
      op(1'b1, 6'h03, 4'h1, 32'h1, 1'b1, 32'h1, "pw_pend_kept");
      chk("pw_irq_hold", {31'h0, irq}, 32'h1);
      rd_chk(6'h03, 32'h0, "pw_pend_cleared");
      chk("pw_irq_low", {31'h0, irq}, 32'h0);
      wr(6'h00, 4'hF, 32'h0, "pw_off");
      wr(6'h03, 4'h1, 32'h1, "pw_w1c_final");

      // Multi-channel IRQ_MAP: ch0 period 3, ch2 period 5
      wr(6'h01, 4'hF, 32'd2, "mc_cmp0");
      wr(6'h02, 4'hF, 32'd0, "mc_cnt0");
      wr(6'h09, 4'hF, 32'd4, "mc_cmp2");
      wr(6'h0A, 4'hF, 32'd0, "mc_cnt2");
      wr(6'h08, 4'hF, 32'h7, "mc_ctrl2");
      wr(6'h00, 4'hF, 32'h7, "mc_ctrl0");
      idle();
      idle();
      idle();
      rd_chk(6'h3C, 32'h1, "mc_map_1");
      rd_chk(6'h3C, 32'h5, "mc_map_5");
      idle();
      wr(6'h03, 4'h1, 32'h1, "mc_w1c0");
      rd_chk(6'h3C, 32'h4, "mc_map_4");
      rd_chk(6'h1C, 32'h0, "mc_ch7");
      wr(6'h00, 4'hF, 32'h0, "mc_off0");
      wr(6'h08, 4'hF, 32'h0, "mc_off2");
      wr(6'h03, 4'h1, 32'h1, "mc_clr0");
      wr(6'h0B, 4'h1, 32'h1, "mc_clr2");

      // Byte-masked COMPARE on the 16-bit instance
      wr(6'h01, 4'hF, 32'h1234_5678, "w16_full");
      rd_chk(6'h01, 32'h1234_5678, "w32_full");
      chk("w16_full_rd", last_r16, 32'h0000_5678);
      wr(6'h01, 4'h1, 32'h0000_00AA, "w16_byte");
      rd_chk(6'h01, 32'h1234_56AA, "w32_byte");
      chk("w16_byte_rd", last_r16, 32'h0000_56AA);

      // Prescaler setup on ch3: PRE=3, COMPARE=1, periodic
      per = PRESC ? 8 : 2;
      wr(6'h0D, 4'hF, 32'd1, "ps_cmp");
      wr(6'h0E, 4'hF, 32'd0, "ps_cnt");
      wr(6'h0C, 4'h3, 32'h0303, "ps_ctrl");
      for (int k = 1; k <= per; k++) rd_chk(6'h0F, 32'h0, $sformatf("ps_wait%0d", k));
      op(1'b1, 6'h0F, 4'h1, 32'h1, 1'b1, 32'h1, "ps_first");
      for (int k = per + 2; k <= 2 * per; k++) rd_chk(6'h0F, 32'h0, $sformatf("ps_gap%0d", k));
      rd_chk(6'h0F, 32'h1, "ps_second");
      rd_chk(6'h0C, PRESC ? 32'h0303 : 32'h0003, "ps_ctrl_rd");
      wr(6'h0C, 4'hF, 32'h0, "ps_off");
      wr(6'h0F, 4'h1, 32'h1, "ps_clr");

      // Randomised traffic against the model
      for (int n = 0; n < 800; n++) begin
         int          pick;
         int          r;
         logic [3:0]  ch;
         logic [3:0]  w;
         logic [31:0] d;
         pick = $urandom_range(0, 11);
         ch = (pick < 8) ? 4'(pick % 4) : ((pick < 10) ? 4'h7 : 4'hF);
         r  = $urandom_range(0, 3);
         w  = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
         case (r)
            0:       d = {16'h0, 8'($urandom_range(0, 3)), 5'h0, 3'($urandom_range(0, 7))};
            1:       d = 32'($urandom_range(0, 9));
            default: d = $urandom;
         endcase
         op($urandom_range(0, 9) != 0, {ch, 2'(r)}, w, d, 1'b0, 32'h0, "rand");
      end

      // Reset in the middle of activity
      wr(6'h05, 4'hF, 32'd0, "rm_cmp");
      wr(6'h06, 4'hF, 32'd0, "rm_cnt");
      wr(6'h04, 4'hF, 32'h7, "rm_ctrl");
      idle();
      idle();
      idle();
      chk("rm_irq_high", {31'h0, irq}, 32'h1);
      resetq = 1'b0;
      idle();
      resetq = 1'b1;
      chk("rm_irq_low", {31'h0, irq}, 32'h0);
      rd_chk(6'h06, 32'h0, "rm_cnt");
      rd_chk(6'h04, 32'h0, "rm_ctrl_rd");
      rd_chk(6'h3C, 32'h0, "rm_map");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
